// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: FSM encodings and default sizes.
package register_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_MAX_LOCK = 8;

endpackage

// File: rtl/register_write_arbiter_rr_select.sv
// Combinational round-robin picker: first set bit of eff_req scanning upward from ptr, wrapping.
module rr_select
    import register_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    localparam int unsigned PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eff_req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    int unsigned j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!valid && eff_req[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter driving one shared Register (load/in) among NREQ requesters.
// Optional burst locking is compiled in with REGARB_LOCK_EN.
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned WIDTH    = DEF_WIDTH
`ifdef REGARB_LOCK_EN
   ,parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef REGARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  reg_load,
    output logic [WIDTH-1:0]      reg_in,
    output logic                  busy
);

    localparam int unsigned PW = $clog2(NREQ);

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [NREQ-1:0]   gnt_n;
    logic              load_n;
    logic [WIDTH-1:0]  din_n;
    logic [NREQ-1:0]   eff_req;
    logic [NREQ-1:0]   sel_onehot;
    logic [PW-1:0]     sel_idx;
    logic              sel_valid;
    logic              arb;

`ifdef REGARB_LOCK_EN
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0]     cnt, cnt_n;
    logic [PW-1:0]     lidx, lidx_n;
`endif

    // The current grantee is masked, which also covers the one-arbitration mask after a forced release.
    assign eff_req = req & ~gnt;
    assign busy    = |gnt;

    rr_select #(.NREQ(NREQ)) u_sel (
        .eff_req (eff_req),
        .ptr     (ptr),
        .onehot  (sel_onehot),
        .idx     (sel_idx),
        .valid   (sel_valid)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = '0;
        load_n  = 1'b0;
        din_n   = reg_in;
        arb     = 1'b1;
`ifdef REGARB_LOCK_EN
        cnt_n   = cnt;
        lidx_n  = lidx;
`endif
        case (state)
`ifdef REGARB_LOCK_EN
            ST_GRANT, ST_LOCKED: begin
                // ptr already points past the grantee, so it simply stays frozen while locked.
                if (req[lidx] && lock[lidx] && gnt[lidx] && (cnt < CW'(MAX_LOCK))) begin
                    arb     = 1'b0;
                    state_n = ST_LOCKED;
                    gnt_n   = gnt;
                    load_n  = 1'b1;
                    din_n   = wdata[lidx*WIDTH +: WIDTH];
                    cnt_n   = cnt + CW'(1);
                end
            end
`endif
            default: ;
        endcase
        if (arb) begin
            if (sel_valid) begin
                state_n = ST_GRANT;
                gnt_n   = sel_onehot;
                load_n  = 1'b1;
                din_n   = wdata[sel_idx*WIDTH +: WIDTH];
                ptr_n   = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
`ifdef REGARB_LOCK_EN
                cnt_n   = CW'(1);
                lidx_n  = sel_idx;
`endif
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            ack      <= '0;
            reg_load <= 1'b0;
            reg_in   <= '0;
`ifdef REGARB_LOCK_EN
            cnt      <= '0;
            lidx     <= '0;
`endif
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt      <= gnt_n;
            ack      <= gnt;
            reg_load <= load_n;
            reg_in   <= din_n;
`ifdef REGARB_LOCK_EN
            cnt      <= cnt_n;
            lidx     <= lidx_n;
`endif
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Scoreboard bench for register_write_arbiter with a behavioural Register model on reg_load/reg_in.
module tb_register_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] wdata;
`ifdef REGARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        reg_load;
    logic [15:0] reg_in;
    logic        busy;
    logic [15:0] reg_out = 16'h0000;

    typedef struct {
        logic [3:0]  g;
        logic [15:0] d;
    } exp_t;

    exp_t gq[$];
    exp_t aq[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    register_write_arbiter #(.NREQ(4), .WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
`ifdef REGARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .ack      (ack),
        .reg_load (reg_load),
        .reg_in   (reg_in),
        .busy     (busy)
    );

    always @(posedge clk) if (reg_load) reg_out <= reg_in;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (reg_load) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", {28'd0, gnt}, 32'd0);
                end else begin
                    exp_t e;
                    e = gq.pop_front();
                    check("gnt", {28'd0, gnt}, {28'd0, e.g});
                    check("reg_in", {16'd0, reg_in}, {16'd0, e.d});
                    check("busy", {31'd0, busy}, 32'd1);
                end
            end else begin
                check("idle_gnt", {28'd0, gnt}, 32'd0);
            end
            if (ack != 4'd0) begin
                if (aq.size() == 0) begin
                    check("unexpected_ack", {28'd0, ack}, 32'd0);
                end else begin
                    exp_t e;
                    e = aq.pop_front();
                    check("ack", {28'd0, ack}, {28'd0, e.g});
                    check("reg_out", {16'd0, reg_out}, {16'd0, e.d});
                end
            end
        end
    end

    task automatic expect_wr(input logic [3:0] g, input logic [15:0] d, input bit with_ack);
        exp_t e;
        e.g = g;
        e.d = d;
        gq.push_back(e);
        if (with_ack) aq.push_back(e);
    endtask

    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "timeout");
    end

    initial begin
        req   = '0;
        wdata = '0;
`ifdef REGARB_LOCK_EN
        lock  = '0;
`endif
        rst_n = 1'b0;
        #1;
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_load", {31'd0, reg_load}, 32'd0);
        check("rst_reg_in", {16'd0, reg_in}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Test 1: idle after reset release
        repeat (4) cyc(4'b0000);
        #3;
        check("idle_load", {31'd0, reg_load}, 32'd0);
        check("idle_ack", {28'd0, ack}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2;

        // Test 2: single write from requester 0
        wdata[15:0] = 16'h8285;
        expect_wr(4'b0001, 16'h8285, 1'b1);
        cyc(4'b0001);
        repeat (3) cyc(4'b0000);

        // Test 3: all requesters held, rotation from ptr=0
        do_reset();
        for (int i = 0; i < 4; i++) wdata[i*16 +: 16] = 16'(11111 + i);
        for (int n = 0; n < 8; n++) expect_wr(4'b0001 << (n % 4), 16'(11111 + (n % 4)), 1'b1);
        repeat (8) cyc(4'b1111);
        repeat (3) cyc(4'b0000);

        // Test 4: ptr=2, req=0011, requester 0 re-asserts after its grant
        do_reset();
        wdata[15:0]  = 16'h0A0A;
        wdata[31:16] = 16'h1B1B;
        expect_wr(4'b0010, 16'h1B1B, 1'b1);
        cyc(4'b0010);
        cyc(4'b0000);
        expect_wr(4'b0001, 16'h0A0A, 1'b1);
        expect_wr(4'b0010, 16'h1B1B, 1'b1);
        expect_wr(4'b0001, 16'h0A0A, 1'b1);
        cyc(4'b0011);
        cyc(4'b0011);
        cyc(4'b0001);
        repeat (3) cyc(4'b0000);

        // Test 5: reset asserted while a grant to requester 2 is in flight
        do_reset();
        wdata[47:32] = 16'hC0DE;
        expect_wr(4'b0100, 16'hC0DE, 1'b0);
        cyc(4'b0100);
        req = 4'b0000;
        #5;
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", {28'd0, gnt}, 32'd0);
        check("midrst_ack", {28'd0, ack}, 32'd0);
        check("midrst_load", {31'd0, reg_load}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_reg_out", {16'd0, reg_out}, 32'h0000_0A0A);
        #1;
        rst_n = 1'b1;
        wdata[47:32] = 16'h5A5A;
        expect_wr(4'b0100, 16'h5A5A, 1'b1);
        cyc(4'b0100);
        repeat (3) cyc(4'b0000);

        // Test 6: requester 0 asks for a burst lock while requester 1 waits
        do_reset();
        wdata[15:0]  = 16'h1111;
        wdata[31:16] = 16'h2222;
`ifdef REGARB_LOCK_EN
        lock = 4'b0001;
        for (int n = 0; n < 8; n++) expect_wr(4'b0001, 16'h1111, 1'b1);
        expect_wr(4'b0010, 16'h2222, 1'b1);
`else
        for (int n = 0; n < 9; n++) begin
            if (n % 2 == 0) expect_wr(4'b0001, 16'h1111, 1'b1);
            else            expect_wr(4'b0010, 16'h2222, 1'b1);
        end
`endif
        repeat (9) cyc(4'b0011);
`ifdef REGARB_LOCK_EN
        lock = 4'b0000;
`endif
        repeat (3) cyc(4'b0000);

        check("pending_grants", gq.size(), 32'd0);
        check("pending_acks", aq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
